slot_reel_ctrl: RTL and testbench

//  Parametrised slot-machine reel engine for the Gambling_Tec game. Owns the credit balance,
//  the N spinning reels, staggered reel stop and win evaluation in hardware, so the CPU only

---
 rtl/slot_reel_ctrl.sv | 135 +++++++++++++
 tb/tb_slot_reel_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_reel_ctrl.sv
// slot_reel_ctrl: reel engine owning credits, N spinning reels, staggered stop and win evaluation.
// Optional SLOT_AUTOSTOP_EN: the spin stops by itself after MAX_SPIN ticks.
module slot_reel_ctrl #(
    parameter int N_REELS      = 3,
    parameter int SYM_W        = 3,
    parameter int NUM_SYM      = 6,
    parameter int CREDIT_W     = 10,
    parameter int INIT_CREDITS = 10,
    parameter int COIN_VAL     = 5,
    parameter int BET          = 1,
    parameter int PAIR_MULT    = 2,
    parameter int JACK_MULT    = 20,
    parameter int STAGGER      = 8,
    parameter int MAX_SPIN     = 120
) (
    input  logic                       clk,
    input  logic                       rstin,
    input  logic                       tick,
    input  logic                       coin,
    input  logic                       start,
    input  logic                       stop,
    output logic [N_REELS*SYM_W-1:0]   reel_sym,
    output logic [N_REELS-1:0]         reel_locked,
    output logic [CREDIT_W-1:0]        credits,
    output logic                       busy,
    output logic                       win,
    output logic [CREDIT_W-1:0]        payout
);
    localparam int STW = $clog2(STAGGER + 1);
    localparam int LIW = (N_REELS > 1) ? $clog2(N_REELS) : 1;
    localparam int VW  = SYM_W + 1;
    localparam logic [31:0] MAXC = (32'd1 << CREDIT_W) - 32'd1;

    typedef enum logic [1:0] {IDLE, SPIN, STOP, EVAL} state_t;

    state_t                     state;
    logic [15:0]                lfsr;
    logic [N_REELS*SYM_W-1:0]   reel_q, reel_nxt;
    logic [STW-1:0]             stag_cnt;
    logic [LIW-1:0]             lock_idx;
    logic [VW-1:0]              v;
    logic                       all_eq, pair, moving, lock_now, take, auto_stop;
    logic [CREDIT_W-1:0]        p, credits_nxt;
    logic [31:0]                sum;

`ifdef SLOT_AUTOSTOP_EN
    logic [$clog2(MAX_SPIN+1)-1:0] spin_cnt;
    assign auto_stop = 32'(spin_cnt) == 32'(MAX_SPIN);
`else
    assign auto_stop = 1'b0;
`endif

    assign reel_sym = reel_q;
    assign busy     = state != IDLE;
    assign win      = state == EVAL && p != '0;
    assign moving   = tick && (state == SPIN || state == STOP);
    assign lock_now = tick && state == STOP && (stag_cnt == '0 || 32'(stag_cnt) == 32'(STAGGER));
    assign take     = state == IDLE && start && 32'(credits) >= 32'(BET);

    // The reel being locked this tick keeps its pre-step value.
    always_comb begin
        reel_nxt = reel_q;
        v = '0;
        for (int i = 0; i < N_REELS; i++) begin
            v = {1'b0, reel_q[i*SYM_W +: SYM_W]} + VW'(1) + VW'(lfsr[i]);
            if (moving && !reel_locked[i] && !(lock_now && lock_idx == LIW'(i)))
                reel_nxt[i*SYM_W +: SYM_W] = (32'(v) >= 32'(NUM_SYM)) ? SYM_W'(32'(v) - 32'(NUM_SYM)) : SYM_W'(v);
        end
    end

    always_comb begin
        all_eq = 1'b1;
        pair = N_REELS == 1;
        for (int i = 1; i < N_REELS; i++) begin
            all_eq = all_eq && reel_q[i*SYM_W +: SYM_W] == reel_q[SYM_W-1:0];
            pair = (i == 1) ? reel_q[i*SYM_W +: SYM_W] == reel_q[SYM_W-1:0] : pair;
        end
        p = all_eq ? CREDIT_W'(BET * JACK_MULT) : pair ? CREDIT_W'(BET * PAIR_MULT) : '0;
        sum = 32'(credits) + (coin ? 32'(COIN_VAL) : 32'd0) + (state == EVAL ? 32'(p) : 32'd0)
              - (take ? 32'(BET) : 32'd0);
        credits_nxt = (sum > MAXC) ? CREDIT_W'(MAXC) : CREDIT_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (!rstin) begin
            state       <= IDLE;
            lfsr        <= 16'hACE1;
            reel_q      <= '0;
            reel_locked <= '1;
            credits     <= CREDIT_W'(INIT_CREDITS);
            payout      <= '0;
            stag_cnt    <= '0;
            lock_idx    <= '0;
`ifdef SLOT_AUTOSTOP_EN
            spin_cnt    <= '0;
`endif
        end else begin
            lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            reel_q  <= reel_nxt;
            credits <= credits_nxt;
            case (state)
                IDLE: if (take) begin
                    state       <= SPIN;
                    reel_locked <= '0;
`ifdef SLOT_AUTOSTOP_EN
                    spin_cnt    <= '0;
`endif
                end
                SPIN: begin
                    if (stop || auto_stop) begin
                        state    <= STOP;
                        stag_cnt <= '0;
                        lock_idx <= '0;
                    end
`ifdef SLOT_AUTOSTOP_EN
                    if (tick) spin_cnt <= spin_cnt + 1'b1;
`endif
                end
                STOP: if (tick) begin
                    stag_cnt <= lock_now ? STW'(1) : stag_cnt + 1'b1;
                    if (lock_now) begin
                        reel_locked[lock_idx] <= 1'b1;
                        lock_idx <= lock_idx + 1'b1;
                        if (lock_idx == LIW'(N_REELS - 1)) state <= EVAL;
                    end
                end
                EVAL: begin
                    payout <= p;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slot_reel_ctrl.sv
// tb_slot_reel_ctrl: directed vector table plus hand sequences for slot_reel_ctrl (default parameters).
module tb_slot_reel_ctrl;
    logic        clk = 1'b0, rstin = 1'b0, tick = 1'b0, coin = 1'b0, start = 1'b0, stop = 1'b0;
    logic [8:0]  reel_sym;
    logic [2:0]  reel_locked;
    logic [9:0]  credits, payout;
    logic        busy, win;
    logic [15:0] m_lfsr;
    logic [8:0]  frc;
    logic [9:0]  fcr;
    int          errs = 0, checks = 0;

    typedef struct {
        logic       coin, start, stop, tick;
        logic       busy;
        logic [2:0] locked;
        int         cred;
    } vec_t;
    vec_t tv[22];

    always #5 clk = ~clk;

    slot_reel_ctrl dut (
        .clk(clk), .rstin(rstin), .tick(tick), .coin(coin), .start(start), .stop(stop),
        .reel_sym(reel_sym), .reel_locked(reel_locked), .credits(credits),
        .busy(busy), .win(win), .payout(payout)
    );

    // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11, seed ACE1.
    always @(posedge clk)
        m_lfsr <= !rstin ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        coin = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        rstin = 1'b0;
        cyc();
        rstin = 1'b1;
    endtask

    function automatic int sym(input logic [8:0] r, input int i);
        return int'(r[i*3 +: 3]);
    endfunction

    function automatic int eval_pay(input logic [8:0] r);
        return (sym(r, 0) == sym(r, 1) && sym(r, 1) == sym(r, 2)) ? 20 : (sym(r, 0) == sym(r, 1)) ? 2 : 0;
    endfunction

    task automatic run_forced(input logic [8:0] rv, input int c0, input int ep);
        start = 1'b1;
        cyc();
        chk("forced_start_credits", credits, c0 - 1);
        frc = rv;
        force dut.reel_q = frc;
        stop = 1'b1;
        cyc();
        repeat (17) begin tick = 1'b1; cyc(); end
        chk("forced_eval_busy", busy, 1);
        chk("forced_eval_win", win, ep != 0);
        chk("forced_eval_locked", reel_locked, 7);
        cyc();
        chk("forced_payout", payout, ep);
        chk("forced_credits", credits, c0 - 1 + ep);
        chk("forced_win_cleared", win, 0);
        chk("forced_idle", busy, 0);
        release dut.reel_q;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] old;
        logic [15:0] lf;
        logic [2:0] r0_pre, r1_pre;
        int ep, e;

        tv[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 9};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 9};
        for (int k = 2; k <= 18; k++)
            tv[k] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (k < 10) ? 3'b001 : (k < 18) ? 3'b011 : 3'b111, 9};
        tv[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, -1};
        tv[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, -1};
        tv[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, -1};
        r0_pre = '0; r1_pre = '0; ep = 0;

        do_reset();
        chk("rst_credits", credits, 10);
        chk("rst_reel_sym", reel_sym, 0);
        chk("rst_locked", reel_locked, 7);
        chk("rst_busy", busy, 0);
        chk("rst_payout", payout, 0);
        chk("rst_win", win, 0);
        tick = 1'b1;
        cyc();
        chk("idle_tick_no_step", reel_sym, 0);

        for (int k = 0; k < 22; k++) begin
            if (k == 2) r0_pre = reel_sym[2:0];
            if (k == 10) r1_pre = reel_sym[5:3];
            coin = tv[k].coin; start = tv[k].start; stop = tv[k].stop; tick = tv[k].tick;
            cyc();
            chk($sformatf("vec%0d_busy", k), busy, tv[k].busy);
            chk($sformatf("vec%0d_locked", k), reel_locked, tv[k].locked);
            if (tv[k].cred >= 0) chk($sformatf("vec%0d_credits", k), credits, tv[k].cred);
            if (k == 18) begin
                ep = eval_pay(reel_sym);
                chk("spin_eval_win", win, ep != 0);
            end
            if (k == 19) begin
                chk("spin_payout", payout, ep);
                chk("spin_credits", credits, 9 + ep);
            end
        end
        chk("reel0_holds_prestep", reel_sym[2:0], r0_pre);
        chk("reel1_holds_prestep", reel_sym[5:3], r1_pre);

        // Per-tick stepping against the reference LFSR.
        do_reset();
        start = 1'b1;
        cyc();
        for (int t = 0; t < 6; t++) begin
            if (t[0]) cyc();
            lf = m_lfsr;
            old = reel_sym;
            tick = 1'b1;
            cyc();
            for (int i = 0; i < 3; i++) begin
                e = sym(old, i) + 1 + int'(lf[i]);
                e = (e >= 6) ? e - 6 : e;
                chk($sformatf("step%0d_reel%0d", t, i), sym(reel_sym, i), e);
            end
        end

        do_reset();
        run_forced({3'd2, 3'd2, 3'd2}, 10, 20);
        run_forced({3'd1, 3'd4, 3'd4}, 29, 2);
        run_forced({3'd1, 3'd3, 3'd1}, 30, 0);

        fcr = 10'd0;
        force dut.credits = fcr;
        cyc();
        release dut.credits;
        chk("drained_credits", credits, 0);
        start = 1'b1;
        cyc();
        chk("nocredit_busy", busy, 0);
        chk("nocredit_credits", credits, 0);
        chk("nocredit_locked", reel_locked, 7);
        coin = 1'b1; start = 1'b1;
        cyc();
        chk("coin_start_zero_credits", credits, 5);
        chk("coin_start_zero_busy", busy, 0);
        coin = 1'b1; start = 1'b1;
        cyc();
        chk("coin_start_net", credits, 9);
        chk("coin_start_spins", busy, 1);

        do_reset();
        fcr = 10'd1020;
        force dut.credits = fcr;
        cyc();
        release dut.credits;
        coin = 1'b1;
        cyc();
        chk("sat_coin1", credits, 1023);
        coin = 1'b1;
        cyc();
        chk("sat_coin2", credits, 1023);
        coin = 1'b1; start = 1'b1;
        cyc();
        chk("sat_coin_start", credits, 1023);
        stop = 1'b1;
        cyc();
        repeat (3) begin tick = 1'b1; cyc(); end
        chk("stop_partial_locked", reel_locked, 1);
        rstin = 1'b0;
        cyc();
        rstin = 1'b1;
        chk("midstop_rst_credits", credits, 10);
        chk("midstop_rst_reels", reel_sym, 0);
        chk("midstop_rst_locked", reel_locked, 7);
        chk("midstop_rst_busy", busy, 0);
        chk("midstop_rst_payout", payout, 0);

        start = 1'b1;
        cyc();
`ifdef SLOT_AUTOSTOP_EN
        repeat (120) begin tick = 1'b1; cyc(); end
        cyc();
        repeat (16) begin tick = 1'b1; cyc(); end
        chk("auto_locked_16", reel_locked, 3);
        tick = 1'b1;
        cyc();
        chk("auto_locked_17", reel_locked, 7);
        chk("auto_eval_busy", busy, 1);
`else
        repeat (500) begin tick = 1'b1; cyc(); end
        chk("noauto_busy", busy, 1);
        chk("noauto_locked", reel_locked, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
